// File: rtl/ycr_imem_pkg.sv
// Shared AHB-Lite constants, core memory response codes and FSM encoding
// for the IMEM-to-AHB prefetch bridge.
package ycr_imem_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [2:0] HBURST_SINGLE = 3'b000;
    localparam logic [2:0] HSIZE_32      = 3'b010;
    localparam logic [2:0] HSIZE_64      = 3'b011;
    localparam logic       HRESP_OKAY    = 1'b0;
    localparam logic       HRESP_ERROR   = 1'b1;
    localparam logic [3:0] HPROT_NONE    = 4'b0000;

    typedef enum logic [1:0] {
        MEM_RESP_NOTRDY = 2'b00,
        MEM_RESP_RDY_OK = 2'b01,
        MEM_RESP_RDY_ER = 2'b10
    } mem_resp_e;

    typedef enum logic [1:0] {
        FSM_ADDR  = 2'b00,
        FSM_DATA  = 2'b01,
        FSM_DRAIN = 2'b10
    } fsm_e;

    function automatic logic [2:0] hsize_from_dw(input int dw);
        return (dw == 64) ? HSIZE_64 : HSIZE_32;
    endfunction

endpackage

// File: rtl/ycr_sync_fifo_flush.sv
// Synchronous circular FIFO with a registered head and a flush that keeps
// a same-cycle push as the sole surviving entry.
module ycr_sync_fifo_flush #(
    parameter int W     = 32,
    parameter int DEPTH = 2
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           push,
    input  logic [W-1:0]                   din,
    input  logic                           pop,
    input  logic                           flush,
    output logic [W-1:0]                   head,
    output logic [$clog2(DEPTH+1)-1:0]     count,
    output logic                           full,
    output logic                           empty
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH+1);

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] rd_q, rd_d, wr_q, wr_d, wr_idx;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          push_i, pop_i, we;

    function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH-1)) ? '0 : p + 1'b1;
    endfunction

    assign full  = (cnt_q == CW'(DEPTH));
    assign empty = (cnt_q == '0);
    assign count = cnt_q;
    assign head  = mem_q[rd_q];

    always_comb begin
        push_i = push & ~full;
        pop_i  = pop & ~empty;
        rd_d   = rd_q;
        wr_d   = wr_q;
        cnt_d  = cnt_q;
        we     = 1'b0;
        wr_idx = wr_q;
        if (flush) begin
            // Restart at slot 0 so a surviving push lands directly at the head.
            rd_d  = '0;
            wr_d  = '0;
            cnt_d = '0;
            if (push_i) begin
                we     = 1'b1;
                wr_idx = '0;
                wr_d   = inc('0);
                cnt_d  = CW'(1);
            end
        end else begin
            if (push_i) begin
                we   = 1'b1;
                wr_d = inc(wr_q);
            end
            if (pop_i) rd_d = inc(rd_q);
            cnt_d = cnt_q + CW'(push_i) - CW'(pop_i);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            rd_q  <= rd_d;
            wr_q  <= wr_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (we) mem_q[wr_idx] <= din;
    end

endmodule

// File: rtl/ycr_imem_ahb_pf.sv
// Instruction-fetch bridge: queues core IMEM requests and issues them as
// pipelined single AHB-Lite reads, with flush, optional bypass and error drain.
module ycr_imem_ahb_pf
    import ycr_imem_pkg::*;
#(
    parameter int AW        = 32,
    parameter int DW        = 32,
    parameter int REQ_DEPTH = 2,
    parameter int IN_BP     = 0,
    parameter int ERR_DRAIN = 0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          imem_req,
    output logic          imem_req_ack,
    input  logic [AW-1:0] imem_addr,
    input  logic          imem_flush,
    output logic [DW-1:0] imem_rdata,
    output logic [1:0]    imem_resp,
    output logic [3:0]    hprot,
    output logic [2:0]    hburst,
    output logic [2:0]    hsize,
    output logic [1:0]    htrans,
    output logic          hmastlock,
    output logic [AW-1:0] haddr,
    input  logic          hready,
    input  logic [DW-1:0] hrdata,
    input  logic          hresp
);

    localparam int CW = $clog2(REQ_DEPTH+1);

    fsm_e          fsm_q, fsm_d;
    logic          drop_q, drop_d;
    mem_resp_e     resp_q, resp_d, cur_resp;
    logic [DW-1:0] rdata_q, rdata_d;

    logic          q_push, q_pop, q_full, q_empty;
    logic [CW-1:0] q_count;
    logic [AW-1:0] q_head;
    logic          data_done, issue, drain_pop;

    ycr_sync_fifo_flush #(.W(AW), .DEPTH(REQ_DEPTH)) u_req_q (
        .clk   (clk),
        .rst   (rst),
        .push  (q_push),
        .din   (imem_addr),
        .pop   (q_pop),
        .flush (imem_flush),
        .head  (q_head),
        .count (q_count),
        .full  (q_full),
        .empty (q_empty)
    );

    always_comb begin
        q_push    = imem_req & ~q_full;
        data_done = (fsm_q == FSM_DATA) & hready;
        issue     = ~q_empty & ~imem_flush &
                    ((fsm_q == FSM_ADDR) | (data_done & (hresp == HRESP_OKAY)));
        drain_pop = (fsm_q == FSM_DRAIN) & ~q_empty & ~imem_flush;
        q_pop     = (issue & hready) | drain_pop;

        fsm_d = fsm_q;
        case (fsm_q)
            FSM_ADDR: if (issue & hready) fsm_d = FSM_DATA;
            FSM_DATA: begin
                if (hready) begin
                    if (hresp == HRESP_ERROR)
                        fsm_d = (ERR_DRAIN != 0 && !q_empty && !imem_flush) ? FSM_DRAIN : FSM_ADDR;
                    else
                        fsm_d = issue ? FSM_DATA : FSM_ADDR;
                end
            end
            FSM_DRAIN: begin
                // A push landing on the last drained entry is a post-error fetch and gets drained too.
                if (imem_flush || q_empty || (q_count == CW'(1) && !q_push)) fsm_d = FSM_ADDR;
            end
            default: fsm_d = FSM_ADDR;
        endcase

        drop_d = drop_q;
        if (data_done) drop_d = 1'b0;
        else if (imem_flush && fsm_q == FSM_DATA) drop_d = 1'b1;

        cur_resp = MEM_RESP_NOTRDY;
        if (data_done && !drop_q && !imem_flush)
            cur_resp = (hresp == HRESP_ERROR) ? MEM_RESP_RDY_ER : MEM_RESP_RDY_OK;
        else if (drain_pop)
            cur_resp = MEM_RESP_RDY_ER;

        resp_d  = cur_resp;
        rdata_d = data_done ? hrdata : rdata_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm_q  <= FSM_ADDR;
            drop_q <= 1'b0;
            resp_q <= MEM_RESP_NOTRDY;
        end else begin
            fsm_q  <= fsm_d;
            drop_q <= drop_d;
            resp_q <= resp_d;
        end
    end

    always_ff @(posedge clk) begin
        rdata_q <= rdata_d;
    end

    assign imem_req_ack = ~q_full;
    assign imem_resp    = (IN_BP != 0) ? cur_resp : resp_q;
    assign imem_rdata   = (IN_BP != 0) ? hrdata : rdata_q;
    assign htrans       = issue ? HTRANS_NONSEQ : HTRANS_IDLE;
    assign haddr        = q_head;
    assign hprot        = HPROT_NONE;
    assign hburst       = HBURST_SINGLE;
    assign hsize        = hsize_from_dw(DW);
    assign hmastlock    = 1'b0;

endmodule

// File: tb/tb_ycr_imem_ahb_pf.sv
// Bench for ycr_imem_ahb_pf: AHB slave model, queue-based reference of expected
// fetch responses, directed scenarios followed by randomized traffic.
module tb_ycr_imem_ahb_pf;
    import ycr_imem_pkg::*;

    localparam int AW = 32, DW = 32, REQ_DEPTH = 4, IN_BP = 0, ERR_DRAIN = 1;

    logic          clk = 1'b0, rst;
    logic          imem_req, imem_req_ack, imem_flush;
    logic [AW-1:0] imem_addr, haddr;
    logic [DW-1:0] imem_rdata, hrdata;
    logic [1:0]    imem_resp, htrans;
    logic [3:0]    hprot;
    logic [2:0]    hburst, hsize;
    logic          hmastlock, hready, hresp;

    ycr_imem_ahb_pf #(.AW(AW), .DW(DW), .REQ_DEPTH(REQ_DEPTH), .IN_BP(IN_BP), .ERR_DRAIN(ERR_DRAIN)) dut (
        .clk(clk), .rst(rst), .imem_req(imem_req), .imem_req_ack(imem_req_ack),
        .imem_addr(imem_addr), .imem_flush(imem_flush), .imem_rdata(imem_rdata),
        .imem_resp(imem_resp), .hprot(hprot), .hburst(hburst), .hsize(hsize),
        .htrans(htrans), .hmastlock(hmastlock), .haddr(haddr), .hready(hready),
        .hrdata(hrdata), .hresp(hresp)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int nerr = 0, nchk = 0;
    logic [31:0] exp_q[$];
    logic [31:0] nseq_addr[$];
    int          nseq_cyc[$];
    int          resp_cyc[$];
    int          n_ok = 0, n_er = 0, run = 0, max_run = 0;
    int          force_waits = -1, max_waits = 0;

    function automatic logic [31:0] fdat(input logic [31:0] a);
        return {a[15:0], ~a[15:0]};
    endfunction

    function automatic logic is_err(input logic [31:0] a);
        return a[15:8] == 8'h04;
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // AHB slave: one data phase per accepted NONSEQ, random waits, two-cycle error
    initial begin : slave
        logic        t_acc, t_done, t_rst, in_dp;
        logic [31:0] t_addr, dp_addr;
        int          wleft;
        bit          estage;
        hready = 1'b1; hresp = 1'b0; hrdata = '0;
        in_dp = 1'b0; dp_addr = '0; wleft = 0; estage = 1'b0;
        forever begin
            @(negedge clk);
            t_rst  = rst;
            t_acc  = !rst && htrans == HTRANS_NONSEQ && hready;
            t_done = !rst && in_dp && hready;
            t_addr = haddr;
            if (t_acc) begin
                nseq_addr.push_back(haddr);
                nseq_cyc.push_back(cyc);
            end
            @(posedge clk);
            #1;
            if (t_done) in_dp = 1'b0;
            if (t_acc) begin
                in_dp   = 1'b1;
                dp_addr = t_addr;
                wleft   = (force_waits >= 0) ? force_waits : int'($urandom_range(max_waits));
                force_waits = -1;
                estage  = 1'b0;
            end
            if (t_rst) in_dp = 1'b0;
            if (!in_dp) begin
                hready = 1'b1; hresp = 1'b0; hrdata = $urandom;
            end else if (wleft > 0) begin
                hready = 1'b0; hresp = 1'b0; hrdata = $urandom; wleft--;
            end else if (is_err(dp_addr) && !estage) begin
                hready = 1'b0; hresp = 1'b1; estage = 1'b1;
            end else begin
                hready = 1'b1; hresp = is_err(dp_addr); hrdata = fdat(dp_addr);
            end
        end
    end

    // Scoreboard feed: accepted requests enter the expected queue, flush empties it
    initial begin : recorder
        logic        r_push, r_flush;
        logic [31:0] r_addr;
        forever begin
            @(negedge clk);
            r_push  = !rst && imem_req && imem_req_ack;
            r_flush = !rst && imem_flush;
            r_addr  = imem_addr;
            @(posedge clk);
            if (rst) exp_q.delete();
            else begin
                if (r_flush) exp_q.delete();
                if (r_push) exp_q.push_back(r_addr);
            end
        end
    end

    // Monitor: every core response must match the oldest surviving request
    initial begin : monitor
        logic [31:0] a;
        bit          prev_er;
        prev_er = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_er = 1'b0; run = 0;
            end else begin
                if (imem_flush) chk("htrans_idle_on_flush", htrans, HTRANS_IDLE);
                if (hresp) chk("htrans_idle_on_error", htrans, HTRANS_IDLE);
                if (imem_resp != MEM_RESP_NOTRDY) begin
                    resp_cyc.push_back(cyc);
                    if (exp_q.size() == 0) chk("resp_unexpected", imem_resp, MEM_RESP_NOTRDY);
                    else begin
                        a = exp_q.pop_front();
                        if (is_err(a) || (prev_er && imem_resp == MEM_RESP_RDY_ER))
                            chk("resp_err", imem_resp, MEM_RESP_RDY_ER);
                        else begin
                            chk("resp_ok", imem_resp, MEM_RESP_RDY_OK);
                            if (imem_resp == MEM_RESP_RDY_OK) chk("rdata", imem_rdata, fdat(a));
                        end
                    end
                    if (imem_resp == MEM_RESP_RDY_ER) begin
                        n_er++; run++;
                        if (run > max_run) max_run = run;
                    end else begin
                        n_ok++; run = 0;
                    end
                end else run = 0;
                prev_er = (imem_resp == MEM_RESP_RDY_ER);
            end
        end
    end

    task automatic send(input logic [31:0] a);
        int k = 0;
        imem_req = 1'b1; imem_addr = a;
        while (!imem_req_ack && k < 50) begin tick(); k++; end
        chk("send_ack", imem_req_ack, 1'b1);
        tick();
        imem_req = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int k = 0;
        while (exp_q.size() != 0 && k < 80) begin tick(); k++; end
        repeat (4) tick();
        chk({name, "_drained"}, exp_q.size(), 0);
    endtask

    task automatic clear_logs();
        nseq_addr.delete(); nseq_cyc.delete(); resp_cyc.delete(); max_run = 0;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: run did not complete (errors=%0d)", nerr);
        $fatal(1);
    end

    initial begin : stim
        int c0, ok0, er0, acc;
        rst = 1'b1; imem_req = 1'b0; imem_flush = 1'b0; imem_addr = '0;
        repeat (3) tick();
        chk("rst_htrans", htrans, HTRANS_IDLE);
        chk("rst_resp", imem_resp, MEM_RESP_NOTRDY);
        chk("rst_ack", imem_req_ack, 1'b1);
        chk("hprot", hprot, 4'b0000);
        chk("hburst", hburst, 3'b000);
        chk("hsize", hsize, 3'b010);
        chk("hmastlock", hmastlock, 1'b0);
        rst = 1'b0;
        repeat (2) tick();

        // back-to-back fetches, zero-wait slave
        clear_logs(); ok0 = n_ok; c0 = cyc;
        send(32'h100); send(32'h104); send(32'h108);
        wait_drain("b2b");
        chk("b2b_nseq_count", nseq_addr.size(), 3);
        for (int i = 0; i < 3 && i < nseq_addr.size(); i++) begin
            chk("b2b_haddr", nseq_addr[i], 32'h100 + 4 * i);
            chk("b2b_nseq_cycle", nseq_cyc[i], c0 + 1 + i);
        end
        chk("b2b_ok_count", n_ok - ok0, 3);
        if (resp_cyc.size() > 0) chk("b2b_first_latency", resp_cyc[0], c0 + 3);

        // stalled data phase fills the queue
        clear_logs(); ok0 = n_ok; acc = 0; force_waits = 6;
        for (int i = 0; i < 8; i++) begin
            imem_req = 1'b1; imem_addr = 32'h600 + 4 * i;
            if (!imem_req_ack) break;
            tick(); acc++;
        end
        chk("stall_ack_low", imem_req_ack, 1'b0);
        chk("stall_accepts", acc, 5);
        imem_req = 1'b0;
        wait_drain("stall");
        chk("stall_ok_count", n_ok - ok0, 5);

        // flush with one in flight and two queued, new request in the flush cycle
        clear_logs(); ok0 = n_ok; force_waits = 3;
        send(32'h200); send(32'h204); send(32'h208);
        imem_flush = 1'b1; imem_req = 1'b1; imem_addr = 32'h300;
        tick();
        imem_flush = 1'b0; imem_req = 1'b0;
        wait_drain("flush");
        chk("flush_nseq_count", nseq_addr.size(), 2);
        if (nseq_addr.size() == 2) chk("flush_next_haddr", nseq_addr[1], 32'h300);
        chk("flush_ok_count", n_ok - ok0, 1);

        // two-cycle bus error, nothing queued behind it
        clear_logs(); ok0 = n_ok; er0 = n_er;
        send(32'h400);
        wait_drain("err");
        chk("err_er_count", n_er - er0, 1);
        chk("err_ok_count", n_ok - ok0, 0);

        // error drain with three queued entries
        clear_logs(); ok0 = n_ok; er0 = n_er; force_waits = 2;
        send(32'h400); send(32'h500); send(32'h504); send(32'h508);
        wait_drain("drain");
        chk("drain_er_count", n_er - er0, 4);
        chk("drain_er_run", max_run, 4);
        chk("drain_no_nseq", nseq_addr.size(), 1);
        send(32'h50C);
        wait_drain("post_drain");
        chk("post_drain_ok", n_ok - ok0, 1);
        if (nseq_addr.size() > 0) chk("post_drain_haddr", nseq_addr[nseq_addr.size()-1], 32'h50C);

        // reset mid-transfer with a full queue
        clear_logs(); force_waits = 8;
        for (int i = 0; i < 5; i++) send(32'h700 + 4 * i);
        chk("pre_reset_full", imem_req_ack, 1'b0);
        rst = 1'b1;
        #1;
        chk("mid_rst_htrans", htrans, HTRANS_IDLE);
        chk("mid_rst_resp", imem_resp, MEM_RESP_NOTRDY);
        chk("mid_rst_ack", imem_req_ack, 1'b1);
        repeat (2) tick();
        rst = 1'b0;
        repeat (2) tick();
        clear_logs(); ok0 = n_ok;
        send(32'h710);
        wait_drain("post_rst");
        chk("post_rst_ok", n_ok - ok0, 1);
        if (nseq_addr.size() > 0) chk("post_rst_haddr", nseq_addr[0], 32'h710);

        // randomized traffic with flushes and wait states
        max_waits = 2;
        for (int i = 0; i < 400; i++) begin
            imem_req   = ($urandom_range(9) < 6);
            imem_addr  = 32'h1000 + ($urandom_range(32'hBFF) << 2);
            imem_flush = ($urandom_range(24) == 0);
            tick();
        end
        imem_req = 1'b0; imem_flush = 1'b0;
        wait_drain("rand");

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
